// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per
// cycle, followed by a one-cycle sign fix-up. Results appear on hi/lo with a done pulse.
module mult_div_unit #(
  parameter int WIDTH         = 32,
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_res_q, neg_res_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes; in unsigned mode the raw bit patterns pass straight through.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic             cnt_last;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
  assign cnt_last  = (cnt_q == CW'(WIDTH - 1));
  assign rem_fix   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every target gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_res_d  = neg_res_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE, so a start that overlaps it is dropped here.
        if (start && !done_q) begin
          op_d       = op;
          neg_a_d    = a_neg;
          neg_res_d  = a_neg ^ b_neg;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          opnd_d     = op ? b_mag : a_mag;
          acc_d      = {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
          if (!op) begin
            state_d = MULT;
          end else if (b == '0) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      MULT: begin
        acc_d = {mult_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) state_d = FIX;
      end
      DIV: begin
        acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) state_d = FIX;
      end
      FIX: begin
        acc_d   = op_q ? {rem_fix, quo_fix} : (neg_res_q ? -acc_q : acc_q);
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        if (!div_zero_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_res_q  <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_res_q  <= neg_res_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  generate
    if (ZERO_ON_RESET) begin : g_hilo_rst
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hi_q <= '0;
          lo_q <= '0;
        end else begin
          hi_q <= hi_d;
          lo_q <= lo_d;
        end
      end
    end else begin : g_hilo_norst
      // NOTE: result registers deliberately have no reset here; they power up unknown.
      always_ff @(posedge clock) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  endgenerate

  assign busy     = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a latency-countdown reference model with plain-arithmetic
// results, a per-cycle compare process, and directed literal cases.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock, reset, start, op, is_signed;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  mult_div_unit #(.WIDTH(W), .ZERO_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_op(input logic o, input logic s, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output logic [W-1:0] h,
                                 output logic [W-1:0] l, output logic dz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    dz = 1'b0;
    h  = '0;
    l  = '0;
    if (!o) begin
      if (s) p = longint'($signed(x)) * longint'($signed(y));
      else   p = {32'b0, x} * {32'b0, y};
      h = p[63:32];
      l = p[31:0];
    end else if (y == '0) begin
      dz = 1'b1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      l  = q[31:0];
      h  = r[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  // Model: cycles remaining until the done pulse, plus the visible result registers.
  int           m_cnt = 0;
  logic         m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clock or negedge reset) begin
    logic prev_done, dz;
    if (!reset) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      prev_done = m_done;
      m_done    = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          if (!m_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start && !prev_done) begin
        ref_op(op, is_signed, a, b, p_hi, p_lo, dz);
        m_dz  = dz;
        m_cnt = dz ? 1 : W + 2;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, (m_cnt >= 2)});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("div_zero", {63'b0, div_zero}, {63'b0, m_dz});
      check("hi", {32'b0, hi}, {32'b0, m_hi});
      check("lo", {32'b0, lo}, {32'b0, m_lo});
    end
  end

  // Waits for done, counting edges after the start edge; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic o, input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit noise, output int lat);
    @(posedge clock); #1;
    start = 1'b1; op = o; is_signed = s; a = av; b = bv;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
        is_signed = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 64'(lat), ((o && bv == '0) ? 64'd1 : 64'd34));
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int done_seen;
    start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dz", {63'b0, div_zero}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    #2 reset = 1'b1;

    // Directed cases with hand-computed results.
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("umul_max_lat", 64'(lat), 64'd34);
    check("umul_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("umul_max_lo", {32'b0, lo}, 64'h0000_0001);

    do_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, lat);
    check("smul_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("smul_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    do_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, lat);
    check("umul_hi", {32'b0, hi}, 64'h6);
    check("umul_lo", {32'b0, lo}, 64'hFFFF_FFEB);

    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    check("sdiv_q", {32'b0, lo}, 64'hFFFF_FFFD);
    check("sdiv_r", {32'b0, hi}, 64'hFFFF_FFFF);
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, lat);
    check("udiv_q", {32'b0, lo}, 64'd14);
    check("udiv_r", {32'b0, hi}, 64'd2);

    do_op(1'b1, 1'b0, 32'h451, 32'h20, 1'b0, lat);
    check("prep_hi", {32'b0, hi}, 64'h11);
    check("prep_lo", {32'b0, lo}, 64'h22);
    do_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, lat);
    check("dz_lat", 64'(lat), 64'd1);
    check("dz_flag", {63'b0, div_zero}, 64'd1);
    check("dz_hi", {32'b0, hi}, 64'h11);
    check("dz_lo", {32'b0, lo}, 64'h22);
    do_op(1'b0, 1'b0, 32'd3, 32'd3, 1'b0, lat);
    check("dz_cleared", {63'b0, div_zero}, 64'd0);

    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    check("ovf_q", {32'b0, lo}, 64'h8000_0000);
    check("ovf_r", {32'b0, hi}, 64'h0);
    check("ovf_dz", {63'b0, div_zero}, 64'd0);

    // Back-to-back: start held through the done cycle must only take effect one cycle later.
    start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd1; b = 32'd1;
    @(posedge clock); #1;
    a = 32'd9; b = 32'd11;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_lo", {32'b0, lo}, 64'd99);

    // Reset in the middle of a multiply, with start pulses while busy.
    @(posedge clock); #1;
    start = 1'b1; op = 1'b0; is_signed = 1'b1; a = 32'd123; b = 32'd456;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock); #1;
      start = 1'(i % 2);
      a = $urandom;
      b = $urandom;
    end
    #2 reset = 1'b0;
    #1;
    start = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    @(posedge clock);
    @(posedge clock); #3 reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    do_op(1'b0, 1'b0, 32'd6, 32'd7, 1'b0, lat);
    check("post_rst_lat", 64'(lat), 64'd34);
    check("post_rst_lo", {32'b0, lo}, 64'd42);
    check("post_rst_hi", {32'b0, hi}, 64'd0);

    // Randomised operations, some with start noise while busy.
    for (int i = 0; i < 150; i++) begin
      logic         ro, rs;
      logic [W-1:0] ra, rb;
      ro = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = pick_val();
      rb = pick_val();
      do_op(ro, rs, ra, rb, ($urandom_range(0, 3) == 0), lat);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
